ldpc_src_framer: RTL and testbench
==================================

// Module: ldpc_src_framer
// PURPOSE
// - Parametrised ingress framer in front of the LDPC encoder core.
// - Takes IN_W-bit message beats with start/end-of-frame markers and checks frame length against the configured byte count.
// - Packs beats into OUT_W-bit core words and buffers them in a small FIFO.
// - Flags framing errors on src_err and holds off the next frame until the core signals decode completion.
// PARAMETERS
// - IN_W        8   source beat width in bits; multiple of 8 (BPB = IN_W/8 bytes per beat)
// - OUT_W       32  core word width in bits; integer multiple of IN_W (R = OUT_W/IN_W beats per word)
// - LEN_W       13  width of the byte-count config
// - FIFO_DEPTH  4   output FIFO depth; power of 2, >= 2
// PORTS
// - clk               in   1       clock; all logic on rising edge
// - arst_n            in   1       asynchronous active-low reset
// - src_msg           in   IN_W    message beat
// - src_valid         in   1       beat valid
// - src_start_frame   in   1       first beat of frame (qualified by src_valid)
// - src_end_frame     in   1       last beat of frame (qualified by src_valid)
// - src_ready         out  1       beat accepted when src_valid & src_ready
// - src_err           out  1       one-cycle framing-error pulse
// - cfg_num_bytes     in   LEN_W   frame length minus 1, in bytes; sampled on accepted start beat
// - core_data         out  OUT_W   packed word to encoder core
// - core_valid        out  1       word valid
// - core_last         out  1       marks the final word of the frame
// - core_ready        in   1       core accepts word when core_valid & core_ready
// - dst_dec_complete  in   1       one-cycle pulse; releases WAIT_DONE
// - busy              out  1       high in any state other than IDLE
// BEHAVIOUR
// - Reset values: src_ready=0 while arst_n low, 1 from the first clk after release (IDLE); all other outputs 0; FIFO emptied.
// - Reset mid-frame discards the partial word and all FIFO contents.
// - FSM states: IDLE, FILL, WAIT_DONE, ERR.
//   - IDLE: on an accepted beat with start=1, latch total = cfg_num_bytes+1 and expected beats = ceil(total/BPB), then go to FILL.
//     If start=1 and end=1 and expected beats = 1, push a one-word frame and go to WAIT_DONE.
//     An accepted beat with start=0 raises src_err, is dropped, and the FSM stays in IDLE.
//   - FILL: each accepted beat increments a beat counter.
//     - start=1 mid-frame -> error.
//     - end=1 before the last expected beat -> error.
//     - Last expected beat with end=0 -> error.
//     - Last expected beat with end=1 -> push the final word with core_last=1, then go to WAIT_DONE.
//   - WAIT_DONE: src_ready=0. Go to IDLE on a dst_dec_complete pulse seen after the last word has left the FIFO.
//     A pulse received earlier is remembered (sticky flag) and honoured once the FIFO drains.
//   - ERR: src_err=1 for exactly one cycle on entry. The partial word and the unsent words of this frame are flushed.
//     src_ready=1 and beats are dropped until an accepted beat with start=1, which is handled exactly as in IDLE.
// - Packing: beat k of a word occupies bits [(k%R)*IN_W +: IN_W], LSB-first.
//   - A word is pushed when R beats are collected or on the frame's final beat.
//   - Unfilled lanes are zero.
//   - Bytes of the final beat beyond `total` are forced to 0.
// - Latency: a word is visible on core_valid the cycle after the beat that completes it, provided the FIFO was empty.
// - src_ready = (state is IDLE, FILL or ERR) and FIFO not full.
//   A push and a pop in the same cycle on a full FIFO are permitted; src_ready uses the pre-pop count.
// - core_data and core_last stay stable while core_valid=1 and core_ready=0.
// - cfg_num_bytes changes during FILL have no effect.
// - Beat counter width = LEN_W bits; no wrap within a legal frame.
// CONFIGURATION
// - LDPC_FRAMER_MSB_FIRST_EN defined: beat k of a word lands at bits [OUT_W-1-(k%R)*IN_W -: IN_W], MSB-first.
//   Padding bytes then sit in the low lanes.
// - Not defined: LSB-first packing as above. The macro has no other effect.
// TESTING
// - All scenarios use IN_W=8, OUT_W=32, FIFO_DEPTH=4, LSB-first unless stated.
// 1. cfg_num_bytes=7; beats 01..08 with start on 01 and end on 08
//    -> core_data 32'h04030201, then 32'h08070605 with core_last=1; src_err stays 0.
// 2. cfg_num_bytes=5; 6 beats 11..16
//    -> words 32'h14131211 and 32'h00001615 (last); src_ready=0 until the dst_dec_complete pulse.
// 3. cfg_num_bytes=7; end asserted on beat 5
//    -> src_err one-cycle pulse; no core_last; a following start beat is accepted and starts a new frame.
// 4. core_ready held 0 with cfg_num_bytes=23
//    -> exactly 16 beats accepted, then src_ready=0; releasing core_ready drains the 4 words in order.
// 5. Assert arst_n=0 mid-frame
//    -> all outputs 0 immediately, FIFO empty; the next frame packs cleanly.
// 6. Rerun scenario 1 with LDPC_FRAMER_MSB_FIRST_EN defined
//    -> 32'h01020304, then 32'h05060708.

Source files
------------

// File: rtl/ldpc_src_framer.sv
// Ingress framer for the LDPC encoder: checks frame length, packs beats into core words, buffers them in a FIFO.
// Define LDPC_FRAMER_MSB_FIRST_EN to pack beats MSB-first; LSB-first otherwise.
module ldpc_src_framer #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 32,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [IN_W-1:0]  src_msg,
  input  logic             src_valid,
  input  logic             src_start_frame,
  input  logic             src_end_frame,
  output logic             src_ready,
  output logic             src_err,
  input  logic [LEN_W-1:0] cfg_num_bytes,
  output logic [OUT_W-1:0] core_data,
  output logic             core_valid,
  output logic             core_last,
  input  logic             core_ready,
  input  logic             dst_dec_complete,
  output logic             busy
);

  localparam int BPB = IN_W / 8;
  localparam int R   = OUT_W / IN_W;
  localparam int LW  = (R > 1) ? $clog2(R) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam logic [LEN_W-1:0] BPB_L    = LEN_W'(BPB);
  localparam logic [LW-1:0]    LANE_MAX = LW'(R - 1);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_DONE, ERR} state_t;

  state_t           state;
  logic             alive;
  logic [LEN_W-1:0] cnt, last_idx, last_bytes;
  logic [LW-1:0]    lane;
  logic [OUT_W-1:0] acc;
  logic             done_seen;

  logic [OUT_W-1:0]      mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_l;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, empty, accept, pop;

  logic             start_ph, is_last, do_beat, beat_err, err_now, push, idle_err;
  logic [LEN_W-1:0] b_idx, b_last_idx, b_last_bytes;
  logic [LW-1:0]    b_lane, lane_nx;
  logic [IN_W-1:0]  beat_m;
  logic [OUT_W-1:0] word_nx;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign src_ready  = alive && (state != WAIT_DONE) && !full;
  assign accept     = src_valid && src_ready;
  assign core_valid = !empty;
  assign core_data  = empty ? '0 : mem_d[rd_ptr];
  assign core_last  = !empty && mem_l[rd_ptr];
  assign pop        = core_valid && core_ready;
  assign busy       = (state != IDLE);

  // Outside FILL the only beat that matters is a start beat, so its frame geometry comes straight from cfg.
  always_comb begin
    start_ph     = (state != FILL);
    b_last_idx   = start_ph ? cfg_num_bytes / BPB_L : last_idx;
    b_last_bytes = start_ph ? (cfg_num_bytes % BPB_L) + 1'b1 : last_bytes;
    b_idx        = start_ph ? '0 : cnt;
    b_lane       = start_ph ? '0 : lane;
    is_last      = (b_idx == b_last_idx);
    beat_m       = src_msg;
    for (int j = 0; j < BPB; j++)
      if (is_last && LEN_W'(j) >= b_last_bytes) beat_m[j*8 +: 8] = 8'h00;
    word_nx = (b_lane == '0) ? '0 : acc;
    for (int k = 0; k < R; k++)
      if (b_lane == LW'(k))
`ifdef LDPC_FRAMER_MSB_FIRST_EN
        word_nx[OUT_W-1-k*IN_W -: IN_W] = beat_m;
`else
        word_nx[k*IN_W +: IN_W] = beat_m;
`endif
    lane_nx  = (b_lane == LANE_MAX) ? '0 : b_lane + 1'b1;
    do_beat  = accept && (state == FILL || src_start_frame);
    beat_err = (state == FILL && src_start_frame) || (src_end_frame != is_last);
    err_now  = do_beat && beat_err;
    push     = do_beat && !beat_err && (is_last || b_lane == LANE_MAX);
    idle_err = accept && (state == IDLE) && !src_start_frame;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      alive      <= 1'b0;
      src_err    <= 1'b0;
      cnt        <= '0;
      last_idx   <= '0;
      last_bytes <= '0;
      lane       <= '0;
      acc        <= '0;
      done_seen  <= 1'b0;
    end else begin
      alive   <= 1'b1;
      src_err <= err_now || idle_err;
      case (state)
        IDLE, FILL, ERR: begin
          if (do_beat) begin
            if (beat_err) begin
              state <= ERR;
            end else begin
              last_idx   <= b_last_idx;
              last_bytes <= b_last_bytes;
              cnt        <= b_idx + 1'b1;
              lane       <= lane_nx;
              acc        <= word_nx;
              done_seen  <= 1'b0;
              state      <= is_last ? WAIT_DONE : FILL;
            end
          end
        end
        WAIT_DONE: begin
          // An early completion pulse is held until the last word has left the FIFO.
          if (dst_dec_complete) done_seen <= 1'b1;
          if (empty && (done_seen || dst_dec_complete)) begin
            done_seen <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (err_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr] <= word_nx;
      mem_l[wr_ptr] <= is_last;
    end
  end

endmodule

// File: tb/tb_ldpc_src_framer.sv
// Randomized bench for ldpc_src_framer: byte-list reference model, scoreboard on the core side.
module tb_ldpc_src_framer;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  src_msg;
  logic        src_valid, src_start_frame, src_end_frame, src_ready, src_err;
  logic [12:0] cfg_num_bytes;
  logic [31:0] core_data;
  logic        core_valid, core_last, core_ready, dst_dec_complete, busy;

  ldpc_src_framer #(.IN_W(8), .OUT_W(32), .LEN_W(13), .FIFO_DEPTH(4)) dut (
    .clk(clk), .arst_n(arst_n), .src_msg(src_msg), .src_valid(src_valid),
    .src_start_frame(src_start_frame), .src_end_frame(src_end_frame),
    .src_ready(src_ready), .src_err(src_err), .cfg_num_bytes(cfg_num_bytes),
    .core_data(core_data), .core_valid(core_valid), .core_last(core_last),
    .core_ready(core_ready), .dst_dec_complete(dst_dec_complete), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef LDPC_FRAMER_MSB_FIRST_EN
  localparam logic [31:0] W1 = 32'h01020304;
`else
  localparam logic [31:0] W1 = 32'h04030201;
`endif

  typedef struct { logic [31:0] d; logic l; } word_t;
  word_t      exp_q[$];
  logic [7:0] frm[$];
  int n_chk = 0, n_pass = 0, err_cnt = 0, core_mode = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Core-side scoreboard and error-pulse counter.
  always @(negedge clk) begin
    word_t w;
    if (src_err) err_cnt++;
    if (core_valid && core_ready) begin
      if (exp_q.size() == 0) chk("unexp_word", {63'b0, core_valid}, 64'd0);
      else begin
        w = exp_q.pop_front();
        chk("data", core_data, w.d);
        chk("last", core_last, w.l);
      end
    end
  end

  initial begin
    core_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (core_mode)
        0: core_ready = 1'b0;
        1: core_ready = 1'b1;
        default: core_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Words of the first n frame bytes, four bytes per word, zero padded.
  task automatic model_push(input int n, input bit last);
    int nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word_t x;
      x.d = '0;
      for (int k = 0; k < 4; k++) begin
        int i = 4*w + k;
`ifdef LDPC_FRAMER_MSB_FIRST_EN
        if (i < n) x.d[31-8*k -: 8] = frm[i];
`else
        if (i < n) x.d[8*k +: 8] = frm[i];
`endif
      end
      x.l = last && (w == nw - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic fill_seq(input int base, input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'(base + i));
  endtask

  task automatic fill_rand(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_beat(input logic [7:0] d, input bit s, input bit e);
    bit a;
    int cyc = 0;
    src_msg = d; src_start_frame = s; src_end_frame = e; src_valid = 1'b1;
    do begin
      @(negedge clk); a = src_ready;
      @(posedge clk); #1; cyc++;
    end while (!a && cyc < 300);
    src_valid = 1'b0; src_start_frame = 1'b0; src_end_frame = 1'b0;
    chk("beat_accept", a, 1);
  endtask

  // end_idx == cfg: legal frame; < cfg: early end; -1: end missing on the last beat.
  task automatic run_frame(input int cfg, input int end_idx);
    int err_at, e0;
    bit legal;
    legal  = (end_idx == cfg);
    err_at = (end_idx < 0) ? cfg : end_idx;
    cfg_num_bytes = 13'(cfg);
    e0 = err_cnt;
    if (legal) model_push(cfg + 1, 1'b1);
    else       model_push((err_at / 4) * 4, 1'b0);
    for (int i = 0; i <= err_at; i++) send_beat(frm[i], i == 0, i == end_idx);
    if (legal) begin
      chk("wait_rdy", src_ready, 0);
      chk("wait_busy", busy, 1);
    end else begin
      repeat (2) @(posedge clk);
      #1;
      chk("err_pulse", err_cnt - e0, 1);
      chk("err_busy", busy, 1);
      chk("err_rdy", src_ready, 1);
    end
  endtask

  task automatic finish_frame(input bit early);
    int cyc = 0;
    if (!early) begin
      while (core_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
      repeat (2) @(posedge clk);
      #1;
      chk("hold_rdy", src_ready, 0);
    end
    dst_dec_complete = 1'b1;
    @(posedge clk); #1;
    dst_dec_complete = 1'b0;
    cyc = 0;
    while (busy && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk("idle_busy", busy, 0);
    chk("idle_rdy", src_ready, 1);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    int e0, nacc;
    bit a;
    arst_n = 1'b0; src_valid = 1'b0; src_start_frame = 1'b0; src_end_frame = 1'b0;
    src_msg = '0; cfg_num_bytes = '0; dst_dec_complete = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", src_ready, 0);
    chk("rst_vld", core_valid, 0);
    chk("rst_data", core_data, 0);
    chk("rst_last", core_last, 0);
    chk("rst_err", src_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_rdy", src_ready, 1);

    // Two full words; first word visible right after its fourth beat.
    fill_seq(1, 8);
    cfg_num_bytes = 13'd7;
    e0 = err_cnt;
    model_push(8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_beat(frm[i], i == 0, i == 7);
      if (i == 3) begin
        chk("lat_vld", core_valid, 1);
        chk("lat_data", core_data, W1);
      end
    end
    chk("s1_noerr", err_cnt - e0, 0);
    chk("s1_wait_rdy", src_ready, 0);
    finish_frame(1'b0);

    // Short final word, zero padded.
    fill_seq(8'h11, 6);
    run_frame(5, 5);
    finish_frame(1'b0);

    // Early end, then a clean frame from the error state.
    fill_seq(8'h21, 8);
    run_frame(7, 4);
    fill_seq(8'h31, 8);
    run_frame(7, 7);
    finish_frame(1'b0);

    // Non-start beat in idle is dropped with an error pulse.
    e0 = err_cnt;
    send_beat(8'h55, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_err", err_cnt - e0, 1);
    chk("idle_err_busy", busy, 0);

    // Missing end on the last beat.
    fill_rand(6);
    run_frame(5, -1);
    fill_rand(3);
    run_frame(2, 2);
    finish_frame(1'b1);

    // Core stalled: FIFO fills after 16 beats, then drains in order.
    core_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    cfg_num_bytes = 13'd23;
    fill_seq(8'h40, 24);
    model_push(24, 1'b1);
    nacc = 0;
    src_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      src_msg = frm[nacc]; src_start_frame = (nacc == 0); src_end_frame = (nacc == 23);
      @(negedge clk); a = src_ready;
      @(posedge clk); #1;
      if (a) nacc++;
    end
    src_valid = 1'b0; src_start_frame = 1'b0; src_end_frame = 1'b0;
    chk("s4_accepted", nacc, 16);
    chk("s4_full_rdy", src_ready, 0);
    chk("s4_vld", core_valid, 1);
    core_mode = 1;
    for (int i = 16; i < 24; i++) send_beat(frm[i], 1'b0, i == 23);
    chk("s4_wait_rdy", src_ready, 0);
    finish_frame(1'b0);

    // Reset mid-frame with a word sitting in the FIFO.
    core_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    cfg_num_bytes = 13'd7;
    fill_seq(8'h50, 8);
    for (int i = 0; i < 5; i++) send_beat(frm[i], i == 0, 1'b0);
    arst_n = 1'b0;
    #1;
    chk("mrst_rdy", src_ready, 0);
    chk("mrst_vld", core_valid, 0);
    chk("mrst_data", core_data, 0);
    chk("mrst_last", core_last, 0);
    chk("mrst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    core_mode = 1;
    fill_seq(8'h60, 8);
    run_frame(7, 7);
    finish_frame(1'b0);

    // Random frames, random core back-pressure, occasional error frames.
    for (int f = 0; f < 12; f++) begin
      int cfg;
      cfg = $urandom_range(0, 40);
      if ($urandom_range(0, 2) == 0) begin
        core_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        fill_rand(cfg + 1);
        run_frame(cfg, (cfg > 0) ? int'($urandom_range(0, cfg - 1)) : -1);
      end
      core_mode = 2;
      fill_rand(cfg + 1);
      run_frame(cfg, cfg);
      finish_frame(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
